// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// Arbiter FSM states and default bus widths.
package dmem_arbiter_pkg;

    localparam int DWIDTH     = 32;
    localparam int AWIDTH_MEM = 8;

    typedef enum logic [1:0] {
        S_PIPE    = 2'd0,
        S_FORCE_D = 2'd1,
        S_LOCK_D  = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_arb_satcnt.sv
// Saturating up-counter with synchronous clear.
// Used for the debug wait counter and the burst lock counter.
module dmem_arb_satcnt #(
    parameter int W   = 2,
    parameter int MAX = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != W'(MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage (P) and
// the debug/loader port (D), with starvation relief and bounded D bursts.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DWIDTH     = dmem_arbiter_pkg::DWIDTH,
    parameter int AWIDTH     = AWIDTH_MEM,
    parameter int DEPTH      = 1 << AWIDTH_MEM,
    parameter int STARVE_MAX = 4,
    parameter int LOCK_MAX   = 8
) (
    input  logic              a_clk,
    input  logic              a_rst,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [AWIDTH-1:0] p_addr,
    input  logic [DWIDTH-1:0] p_wdata,
    output logic              p_stall,
    output logic [DWIDTH-1:0] p_rdata,
    output logic              p_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [AWIDTH-1:0] d_addr,
    input  logic [DWIDTH-1:0] d_wdata,
    output logic              d_gnt,
    output logic [DWIDTH-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              oob_err,
    output logic              mem_ce,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_store_data,
    input  logic [DWIDTH-1:0] mem_load_data
);

    localparam int WW = $clog2(STARVE_MAX);
    localparam int LW = $clog2(LOCK_MAX + 1);

    state_t          state;
    state_t          nxt;
    logic [WW-1:0]   wait_cnt;
    logic [LW-1:0]   lock_cnt;
    logic            p_win;
    logic            d_win;
    logic            lock_hold;
    logic            oob;
    logic [AWIDTH-1:0] sel_addr;

    dmem_arb_satcnt #(.W(WW), .MAX(STARVE_MAX - 1)) u_wait (
        .clk (a_clk),
        .rst (a_rst),
        .clr (d_win || !d_req),
        .inc (d_req && !d_win),
        .cnt (wait_cnt)
    );

    dmem_arb_satcnt #(.W(LW), .MAX(LOCK_MAX)) u_lock (
        .clk (a_clk),
        .rst (a_rst),
        .clr (nxt != S_LOCK_D),
        .inc (d_win),
        .cnt (lock_cnt)
    );

    // Default arbitration is P-priority; FORCE/LOCK override it for D.
    always_comb begin
        p_win     = p_req;
        d_win     = !p_req && d_req;
        lock_hold = d_req && d_lock && (lock_cnt < LW'(LOCK_MAX));
        nxt       = S_PIPE;
        case (state)
            S_FORCE_D: begin
                if (d_req) begin
                    p_win = 1'b0;
                    d_win = 1'b1;
                end
            end
            S_LOCK_D: begin
                if (lock_hold) begin
                    p_win = 1'b0;
                    d_win = 1'b1;
                end
            end
            default: ;
        endcase
        case (state)
            S_PIPE: begin
                if (d_win && d_lock)
                    nxt = S_LOCK_D;
                else if (d_req && !d_win && wait_cnt == WW'(STARVE_MAX - 1))
                    nxt = S_FORCE_D;
            end
            S_FORCE_D: nxt = (d_win && d_lock) ? S_LOCK_D : S_PIPE;
            S_LOCK_D:  nxt = lock_hold ? S_LOCK_D : S_PIPE;
            default:   nxt = S_PIPE;
        endcase
        if (a_rst) begin
            p_win = 1'b0;
            d_win = 1'b0;
        end
    end

    assign sel_addr = d_win ? d_addr : p_addr;
    assign oob      = int'({1'b0, sel_addr}) >= DEPTH;
    assign p_stall  = p_req && !p_win;
    assign d_gnt    = d_win;

    always_comb begin
        mem_ce         = 1'b0;
        mem_wr_en      = 1'b0;
        mem_rd_en      = 1'b0;
        mem_addr       = '0;
        mem_store_data = '0;
        if (p_win || d_win) begin
            mem_addr       = sel_addr;
            mem_store_data = d_win ? d_wdata : p_wdata;
            mem_ce         = !oob;
            mem_wr_en      = !oob && (d_win ? d_we : p_we);
            mem_rd_en      = !oob && !(d_win ? d_we : p_we);
        end
    end

    always_ff @(posedge a_clk or posedge a_rst) begin
        if (a_rst) begin
            state    <= S_PIPE;
            p_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            p_rdata  <= '0;
            d_rdata  <= '0;
            oob_err  <= 1'b0;
        end else begin
            state    <= nxt;
            p_rvalid <= p_win && !p_we;
            d_rvalid <= d_win && !d_we;
            oob_err  <= (p_win || d_win) && oob;
            if (p_win && !p_we)
                p_rdata <= oob ? '0 : mem_load_data;
            if (d_win && !d_we)
                d_rdata <= oob ? '0 : mem_load_data;
        end
    end

endmodule
